// File: rtl/decoder_grant_arbiter.sv
// Round-robin owner arbiter for a shared 3-to-8 one-hot select.
// Registered index/enable feed the decode; gnt is their decoded form.
module decoder_grant_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arb_en,
    input  logic [7:0]        req,
    output logic [7:0]        gnt,
    output logic [2:0]        gnt_idx,
    output logic              gnt_valid,
    output logic [HOLD_W-1:0] hold_cnt
);

    typedef enum logic {IDLE, GRANT} state_e;

    localparam bit HOLD_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    state_e            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        ptr_q, ptr_d;
    logic              valid_q, valid_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [7:0] others;
    logic [7:0] cand;
    logic [3:0] pick;
    logic       win_ok;
    logic [2:0] win;
    logic       rel;
    logic       timeout;

    // First set bit of v scanning upward from p+1; the bit at p is seen last.
    function automatic logic [3:0] rr_pick(input logic [7:0] v,
                                           input logic [2:0] p);
        logic [2:0] k;
        logic [3:0] r;
        r = '0;
        for (int i = 1; i <= 8; i++) begin
            k = p + 3'(i);
            if (!r[3] && v[k]) r = {1'b1, k};
        end
        return r;
    endfunction

    always_comb begin
        others  = req & ~(8'b1 << idx_q);
        rel     = !req[idx_q];
        timeout = HOLD_EN && (hold_q == HOLD_LAST) && (|others);
        cand    = (state_q == GRANT) ? others : req;
        pick    = rr_pick(cand, ptr_q);
        win_ok  = pick[3];
        win     = pick[2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= 3'd7;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arb_en && win_ok) state_d = GRANT;
            GRANT: begin
                if (!arb_en)              state_d = IDLE;
                else if (rel && !win_ok)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (arb_en && win_ok) begin
                    valid_d = 1'b1;
                    idx_d   = win;
                    ptr_d   = win;
                    hold_d  = '0;
                end else begin
                    valid_d = 1'b0;
                    idx_d   = '0;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!arb_en) begin
                    valid_d = 1'b0;
                    idx_d   = '0;
                    hold_d  = '0;
                end else if (rel || timeout) begin
                    // Release wins over timeout; both hand over to the next winner.
                    if (win_ok) begin
                        valid_d = 1'b1;
                        idx_d   = win;
                        ptr_d   = win;
                    end else begin
                        valid_d = 1'b0;
                        idx_d   = '0;
                    end
                    hold_d = '0;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
                idx_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    assign gnt       = valid_q ? (8'b1 << idx_q) : 8'h00;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// Directed table-driven bench for decoder_grant_arbiter.
// Uses MAX_HOLD=4, HOLD_W=4 so timeout and saturation are reachable quickly.
module tb_decoder_grant_arbiter;

    logic       clk;
    logic       rst_n;
    logic       arb_en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic [3:0] hold_cnt;

    int tests;
    int errors;

    decoder_grant_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_en    (arb_en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .hold_cnt  (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       v;
        logic [3:0] hold;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic e, input logic [7:0] q,
                       input logic [7:0] g, input logic [2:0] i,
                       input logic v, input logic [3:0] h);
        vec_t t;
        t.rst_n = r; t.en = e; t.req = q;
        t.gnt = g; t.idx = i; t.v = v; t.hold = h;
        tv.push_back(t);
    endtask

    task automatic check(input string name, input logic [7:0] eg,
                         input logic [2:0] ei, input logic ev,
                         input logic [3:0] eh);
        tests++;
        if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev ||
            hold_cnt !== eh) begin
            errors++;
            $display("FAIL %s: got gnt=%h idx=%0d valid=%b hold=%0d, want gnt=%h idx=%0d valid=%b hold=%0d",
                     name, gnt, gnt_idx, gnt_valid, hold_cnt,
                     eg, ei, ev, eh);
        end
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        rst_n  = 1'b0;
        arb_en = 1'b0;
        req    = 8'h00;

        // reset and idle
        add(0, 1, 8'hFF, 8'h00, 0, 0, 0);
        add(0, 1, 8'hFF, 8'h00, 0, 0, 0);
        add(1, 1, 8'h00, 8'h00, 0, 0, 0);
        add(1, 1, 8'h00, 8'h00, 0, 0, 0);
        // fairness 0..7,0 back-to-back
        add(1, 1, 8'hFF, 8'h01, 0, 1, 0);
        for (int k = 1; k <= 8; k++)
            add(1, 1, 8'hFF & ~(8'h01 << (k - 1)),
                8'h01 << (k % 8), 3'(k % 8), 1, 0);
        // wrap: owner 6, then 7, then 0
        add(1, 1, 8'h40, 8'h40, 6, 1, 0);
        add(1, 1, 8'h81, 8'h80, 7, 1, 0);
        add(1, 1, 8'h01, 8'h01, 0, 1, 0);
        add(1, 1, 8'h00, 8'h00, 0, 0, 0);
        // enable gating, ptr wraps back to 3
        add(1, 1, 8'h08, 8'h08, 3, 1, 0);
        add(1, 0, 8'h08, 8'h00, 0, 0, 0);
        add(1, 1, 8'h08, 8'h08, 3, 1, 0);
        add(1, 1, 8'h08, 8'h08, 3, 1, 1);
        add(1, 1, 8'h00, 8'h00, 0, 0, 0);
        add(1, 0, 8'hFF, 8'h00, 0, 0, 0);
        add(1, 1, 8'h00, 8'h00, 0, 0, 0);
        // timeout at MAX_HOLD=4
        add(1, 1, 8'h04, 8'h04, 2, 1, 0);
        add(1, 1, 8'h24, 8'h04, 2, 1, 1);
        add(1, 1, 8'h24, 8'h04, 2, 1, 2);
        add(1, 1, 8'h24, 8'h04, 2, 1, 3);
        add(1, 1, 8'h24, 8'h20, 5, 1, 0);
        add(1, 1, 8'h24, 8'h20, 5, 1, 1);
        add(1, 1, 8'h04, 8'h04, 2, 1, 0);
        add(1, 1, 8'h00, 8'h00, 0, 0, 0);

        foreach (tv[n]) begin
            rst_n  = tv[n].rst_n;
            arb_en = tv[n].en;
            req    = tv[n].req;
            @(posedge clk);
            #1;
            check($sformatf("row%0d", n), tv[n].gnt, tv[n].idx,
                  tv[n].v, tv[n].hold);
        end

        // lone owner: no preemption, hold_cnt saturates at 15
        req = 8'h04;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat%0d", i), 8'h04, 3'd2, 1'b1,
                  4'(i > 15 ? 15 : i));
        end
        req = 8'h00;
        @(posedge clk);
        #1;
        check("sat_release", 8'h00, 3'd0, 1'b0, 4'd0);

        // async reset mid-grant
        req = 8'h10;
        @(posedge clk);
        #1;
        check("pre_reset", 8'h10, 3'd4, 1'b1, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 8'h00, 3'd0, 1'b0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset", 8'h10, 3'd4, 1'b1, 4'd0);
        req = 8'h11;
        @(posedge clk);
        #1;
        check("post_reset_hold", 8'h10, 3'd4, 1'b1, 4'd1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
